// File: rtl/mem_arbiter_pkg.sv
// Shared types and default widths for the instruction/data memory arbiter.
package mem_arbiter_pkg;

  localparam int ADDR_W_DEF  = 32;
  localparam int LINE_W_DEF  = 256;
  localparam int TIMEOUT_DEF = 1024;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    SERV_I = 2'd1,
    SERV_D = 2'd2,
    DONE   = 2'd3
  } arb_state_t;

endpackage

// File: rtl/mem_arbiter.sv
// Two-requester (instruction / data cache) arbiter onto a single physical memory port.
//
// state  | meaning
// -------+---------------------------------------------------------------
// IDLE   | no pmem request; pick a pending requester (round-robin on tie)
// SERV_I | instruction line read in flight; waits for pmem_resp
// SERV_D | data line read or write in flight; waits for pmem_resp
// DONE   | one quiet cycle so the served requester can drop its request
//
// Request address/data are not registered: the requester holds them until
// its resp pulse, so pmem_addr/pmem_wdata are muxed straight from the inputs.
module mem_arbiter
  import mem_arbiter_pkg::*;
#(
  parameter int ADDR_W  = ADDR_W_DEF,
  parameter int LINE_W  = LINE_W_DEF,
  parameter int TIMEOUT = TIMEOUT_DEF
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              i_read,
  input  logic [ADDR_W-1:0] i_addr,
  output logic [LINE_W-1:0] i_rdata,
  output logic              i_resp,
  input  logic              d_read,
  input  logic              d_write,
  input  logic [ADDR_W-1:0] d_addr,
  input  logic [LINE_W-1:0] d_wdata,
  output logic [LINE_W-1:0] d_rdata,
  output logic              d_resp,
  output logic              pmem_read,
  output logic              pmem_write,
  output logic [ADDR_W-1:0] pmem_addr,
  output logic [LINE_W-1:0] pmem_wdata,
  input  logic [LINE_W-1:0] pmem_rdata,
  input  logic              pmem_resp,
  output logic              err
);

  // Wide enough to hold TIMEOUT itself so the counter can saturate there.
  localparam int CNT_W = $clog2(TIMEOUT + 1);
  localparam logic [CNT_W-1:0] TMO_CNT = CNT_W'(TIMEOUT);
  localparam logic [CNT_W-1:0] TMO_M1  = CNT_W'(TIMEOUT - 1);

  arb_state_t       state, state_next;
  logic             last_d;      // 1: data side was granted last, instruction wins next tie
  logic [CNT_W-1:0] wait_cnt;
  logic             grant_i, grant_d;
  logic             i_pend, d_pend;
  logic             serving;
  logic             stall;

  assign i_pend  = i_read;
  assign d_pend  = d_read | d_write;
  assign serving = (state == SERV_I) || (state == SERV_D);
  assign stall   = serving && !pmem_resp;

  // Read data is a straight fan-out of memory data; only meaningful in the resp cycle.
  assign i_rdata = pmem_rdata;
  assign d_rdata = pmem_rdata;

  // State, round-robin pointer, timeout counter and sticky error flag.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state    <= IDLE;
      last_d   <= 1'b1;
      wait_cnt <= '0;
      err      <= 1'b0;
    end else begin
      state <= state_next;
      if (grant_i) last_d <= 1'b0;
      else if (grant_d) last_d <= 1'b1;
      // Every SERV state is entered from IDLE, so clearing here resets per transaction.
      if (state == IDLE) begin
        wait_cnt <= '0;
      end else if (stall && (wait_cnt != TMO_CNT)) begin
        wait_cnt <= wait_cnt + CNT_W'(1);
      end
      if (stall && (wait_cnt >= TMO_M1)) err <= 1'b1;
    end
  end

  // Next-state selection, grant decision and pmem/resp drive.
  always_comb begin
    state_next = state;
    grant_i    = 1'b0;
    grant_d    = 1'b0;
    pmem_read  = 1'b0;
    pmem_write = 1'b0;
    pmem_addr  = '0;
    pmem_wdata = d_wdata;
    i_resp     = 1'b0;
    d_resp     = 1'b0;
    case (state)
      IDLE: begin
        if (i_pend && d_pend) begin
          if (last_d) grant_i = 1'b1;
          else        grant_d = 1'b1;
        end else if (i_pend) begin
          grant_i = 1'b1;
        end else if (d_pend) begin
          grant_d = 1'b1;
        end
        if (grant_i)      state_next = SERV_I;
        else if (grant_d) state_next = SERV_D;
      end
      SERV_I: begin
        pmem_read = 1'b1;
        pmem_addr = i_addr;
        if (pmem_resp) begin
          i_resp     = 1'b1;
          state_next = DONE;
        end
      end
      SERV_D: begin
        pmem_addr  = d_addr;
        pmem_write = d_write;
        pmem_read  = d_read & ~d_write;
        if (pmem_resp) begin
          d_resp     = 1'b1;
          state_next = DONE;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
      end
    endcase
  end

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench for mem_arbiter with a transaction-level reference model
// checked every cycle, plus hand-computed scenario expectations.
module tb_mem_arbiter;

  localparam int AW  = 32;
  localparam int LW  = 256;
  localparam int TMO = 1024;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic          i_read = 1'b0;
  logic [AW-1:0] i_addr = '0;
  logic [LW-1:0] i_rdata;
  logic          i_resp;
  logic          d_read = 1'b0;
  logic          d_write = 1'b0;
  logic [AW-1:0] d_addr = '0;
  logic [LW-1:0] d_wdata = '0;
  logic [LW-1:0] d_rdata;
  logic          d_resp;
  logic          pmem_read;
  logic          pmem_write;
  logic [AW-1:0] pmem_addr;
  logic [LW-1:0] pmem_wdata;
  logic [LW-1:0] pmem_rdata = '0;
  logic          pmem_resp = 1'b0;
  logic          err;

  mem_arbiter #(.ADDR_W(AW), .LINE_W(LW), .TIMEOUT(TMO)) dut (
    .clk(clk), .rst_n(rst_n),
    .i_read(i_read), .i_addr(i_addr), .i_rdata(i_rdata), .i_resp(i_resp),
    .d_read(d_read), .d_write(d_write), .d_addr(d_addr), .d_wdata(d_wdata),
    .d_rdata(d_rdata), .d_resp(d_resp),
    .pmem_read(pmem_read), .pmem_write(pmem_write), .pmem_addr(pmem_addr),
    .pmem_wdata(pmem_wdata), .pmem_rdata(pmem_rdata), .pmem_resp(pmem_resp),
    .err(err)
  );

  always #5 clk = ~clk;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [LW-1:0] got, input logic [LW-1:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s got=%0h exp=%0h (t=%0t)", nm, got, exp, $time);
    end
  endtask

  // Memory responder: answers a request after `lat` idle cycles, plus optional stray pulses.
  int lat = 3;
  int spur_req = 0;
  int spur_done = 0;
  initial begin
    int rcnt;
    rcnt = 0;
    forever begin
      @(posedge clk);
      #2;
      if (!rst_n) begin
        pmem_resp = 1'b0;
        rcnt = 0;
      end else if (pmem_resp) begin
        pmem_resp = 1'b0;
        rcnt = 0;
      end else if (pmem_read || pmem_write) begin
        if (rcnt >= lat) begin
          pmem_resp  = 1'b1;
          pmem_rdata = {8{pmem_addr ^ 32'hA5A5_0000}} ^ LW'(cyc);
        end else begin
          rcnt++;
        end
      end else if (spur_req != spur_done) begin
        pmem_resp  = 1'b1;
        pmem_rdata = {8{32'hDEAD_BEEF}};
        spur_done++;
      end
    end
  end

  // Reference model: who owns the memory port, whether we are in the post-service
  // quiet cycle, who won the last grant, and how long the current transaction has waited.
  int m_owner = 0;   // 0 none, 1 instruction, 2 data
  bit m_cool = 1'b0;
  bit m_last_d = 1'b1;
  bit m_err = 1'b0;
  int m_wait = 0;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      m_owner  <= 0;
      m_cool   <= 1'b0;
      m_last_d <= 1'b1;
      m_err    <= 1'b0;
      m_wait   <= 0;
    end else if (m_owner != 0) begin
      if (pmem_resp) begin
        m_owner <= 0;
        m_cool  <= 1'b1;
      end else begin
        m_wait <= m_wait + 1;
        if (m_wait + 1 >= TMO) m_err <= 1'b1;
      end
    end else if (m_cool) begin
      m_cool <= 1'b0;
    end else if (i_read && (d_read || d_write)) begin
      m_owner  <= m_last_d ? 1 : 2;
      m_last_d <= !m_last_d;
      m_wait   <= 0;
    end else if (i_read) begin
      m_owner <= 1; m_last_d <= 1'b0; m_wait <= 0;
    end else if (d_read || d_write) begin
      m_owner <= 2; m_last_d <= 1'b1; m_wait <= 0;
    end
  end

  // Observation counters and response log used by the scenario checks.
  int n_pr = 0, n_pw = 0, n_ir = 0, n_dr = 0;
  int rlog_side[$];
  int rlog_cyc[$];
  bit cmp_on = 1'b0;

  // Per-cycle compare of every output against the model, away from the active edge.
  always @(negedge clk) begin
    if (cmp_on) begin
      logic e_pr, e_pw, e_ir, e_dr;
      e_pr = (m_owner == 1) || ((m_owner == 2) && d_read && !d_write);
      e_pw = (m_owner == 2) && d_write;
      e_ir = (m_owner == 1) && pmem_resp;
      e_dr = (m_owner == 2) && pmem_resp;
      chk("pmem_read", pmem_read, e_pr);
      chk("pmem_write", pmem_write, e_pw);
      chk("i_resp", i_resp, e_ir);
      chk("d_resp", d_resp, e_dr);
      chk("err", err, m_err);
      chk("i_rdata", i_rdata, pmem_rdata);
      chk("d_rdata", d_rdata, pmem_rdata);
      if (m_owner == 1) chk("pmem_addr_i", pmem_addr, i_addr);
      if (m_owner == 2) begin
        chk("pmem_addr_d", pmem_addr, d_addr);
        chk("pmem_wdata", pmem_wdata, d_wdata);
      end
    end
    if (pmem_read) n_pr++;
    if (pmem_write) n_pw++;
    if (i_resp) begin n_ir++; rlog_side.push_back(1); rlog_cyc.push_back(cyc); end
    if (d_resp) begin n_dr++; rlog_side.push_back(2); rlog_cyc.push_back(cyc); end
  end

  task automatic wait_resps(input int n, input int bound, output bit ok);
    int start;
    start = rlog_side.size();
    ok = 1'b0;
    for (int k = 0; k < bound; k++) begin
      @(negedge clk);
      #1;
      if (rlog_side.size() >= start + n) begin
        ok = 1'b1;
        break;
      end
    end
  endtask

  task automatic do_reset();
    @(posedge clk); #3;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #3;
    rst_n = 1'b1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog expired");
    $fatal(1, "watchdog");
  end

  initial begin
    bit ok;
    int b_pr, b_pw, b_ir, b_dr, nl;
    logic [LW-1:0] w;

    #1 rst_n = 1'b0;
    @(negedge clk);
    cmp_on = 1'b1;
    chk("rst_pmem_read", pmem_read, 0);
    chk("rst_pmem_write", pmem_write, 0);
    chk("rst_err", err, 0);
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    repeat (2) @(posedge clk);

    // 1: instruction read alone, latency 3
    b_pr = n_pr; b_ir = n_ir; b_dr = n_dr;
    @(posedge clk); #1;
    i_addr = 32'h60; i_read = 1'b1;
    wait_resps(1, 50, ok);
    chk("s1_done", ok, 1);
    @(posedge clk); #1;
    i_read = 1'b0;
    repeat (3) @(posedge clk);
    chk("s1_pmem_read_cycles", n_pr - b_pr, 4);
    chk("s1_i_resp_count", n_ir - b_ir, 1);
    chk("s1_d_resp_count", n_dr - b_dr, 0);

    // 2: dual request right after reset, instruction first, then the write
    do_reset();
    b_pw = n_pw; b_ir = n_ir; b_dr = n_dr;
    w = {8{32'h1234_5678}};
    @(posedge clk); #1;
    i_addr = 32'h100; i_read = 1'b1;
    d_addr = 32'h200; d_wdata = w; d_write = 1'b1;
    wait_resps(1, 50, ok);
    chk("s2_first_done", ok, 1);
    @(posedge clk); #1;
    i_read = 1'b0;
    wait_resps(1, 50, ok);
    chk("s2_second_done", ok, 1);
    @(posedge clk); #1;
    d_write = 1'b0;
    repeat (3) @(posedge clk);
    nl = rlog_side.size();
    chk("s2_first_is_i", rlog_side[nl-2], 1);
    chk("s2_second_is_d", rlog_side[nl-1], 2);
    chk("s2_write_cycles", n_pw - b_pw, 4);
    chk("s2_i_resp_count", n_ir - b_ir, 1);
    chk("s2_d_resp_count", n_dr - b_dr, 1);

    // 3: both held for four transactions
    @(posedge clk); #1;
    i_addr = 32'h140; i_read = 1'b1;
    d_addr = 32'h240; d_read = 1'b1;
    wait_resps(4, 100, ok);
    chk("s3_done", ok, 1);
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) @(posedge clk);
    nl = rlog_side.size();
    chk("s3_order0", rlog_side[nl-4], 1);
    chk("s3_order1", rlog_side[nl-3], 2);
    chk("s3_order2", rlog_side[nl-2], 1);
    chk("s3_order3", rlog_side[nl-1], 2);
    for (int k = 1; k < 4; k++)
      chk("s3_resp_spacing", rlog_cyc[nl-4+k] - rlog_cyc[nl-5+k], 6);

    // 4: read and write both set, write wins
    b_pr = n_pr; b_pw = n_pw; b_dr = n_dr;
    @(posedge clk); #1;
    d_addr = 32'h300; d_wdata = {8{32'hCAFE_0001}};
    d_read = 1'b1; d_write = 1'b1;
    wait_resps(1, 50, ok);
    chk("s4_done", ok, 1);
    @(posedge clk); #1;
    d_read = 1'b0; d_write = 1'b0;
    repeat (3) @(posedge clk);
    chk("s4_write_cycles", n_pw - b_pw, 4);
    chk("s4_read_cycles", n_pr - b_pr, 0);
    chk("s4_d_resp_count", n_dr - b_dr, 1);

    // 5: memory timeout, transaction still completes
    lat = 1100;
    b_dr = n_dr;
    @(posedge clk); #1;
    d_addr = 32'h400; d_read = 1'b1;
    repeat (1000) @(negedge clk);
    chk("s5_err_before", err, 0);
    wait_resps(1, 200, ok);
    chk("s5_done", ok, 1);
    chk("s5_err_after", err, 1);
    @(posedge clk); #1;
    d_read = 1'b0;
    lat = 3;
    repeat (5) @(posedge clk);
    chk("s5_err_sticky", err, 1);
    chk("s5_d_resp_count", n_dr - b_dr, 1);

    // 6: reset in the middle of a data write
    b_ir = n_ir; b_dr = n_dr;
    @(posedge clk); #1;
    d_addr = 32'h500; d_wdata = {8{32'h0BAD_F00D}}; d_write = 1'b1;
    ok = 1'b0;
    for (int k = 0; k < 20; k++) begin
      @(negedge clk);
      if (pmem_write) begin ok = 1'b1; break; end
    end
    chk("s6_write_started", ok, 1);
    @(posedge clk); #3;
    rst_n = 1'b0;
    #1;
    chk("s6_write_dropped", pmem_write, 0);
    chk("s6_err_cleared", err, 0);
    d_write = 1'b0;
    repeat (2) @(posedge clk);
    #3 rst_n = 1'b1;
    spur_req++;
    repeat (4) @(posedge clk);
    chk("s6_no_d_resp", n_dr - b_dr, 0);
    chk("s6_no_i_resp", n_ir - b_ir, 0);
    @(posedge clk); #1;
    i_addr = 32'h600; i_read = 1'b1;
    d_addr = 32'h700; d_read = 1'b1;
    wait_resps(2, 60, ok);
    chk("s6_done", ok, 1);
    @(posedge clk); #1;
    i_read = 1'b0; d_read = 1'b0;
    repeat (3) @(posedge clk);
    nl = rlog_side.size();
    chk("s6_first_is_i", rlog_side[nl-2], 1);
    chk("s6_second_is_d", rlog_side[nl-1], 2);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
